// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART transmit buffer
// Purpose: common definitions imported by uart_fifo_mem and uart_tx_fifo.
// Contents: UART_ADDR_W (default FIFO address width), UART_DATA_W (byte width),
//           tx_state_t (launch sequencer states).
`timescale 1ns/1ps
package uart_pkg;
   localparam int UART_ADDR_W = 4;
   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - byte RAM behind the transmit FIFO
// Purpose: simple dual-port RAM, 2**ADDR_W x UART_DATA_W, synchronous write, asynchronous read.
// Ports: clk (write clock), wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
// Contents are deliberately not reset.
`timescale 1ns/1ps
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [UART_DATA_W-1:0] rd_data
);
   logic [UART_DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding uart_tx
// Purpose: buffers host bytes in a circular FIFO and launches them one at a time into uart_tx.
// Ports: i_clk, i_rst (async, active high); i_enable (launch permit);
//        i_wr_en/i_wr_data (host write); o_full/o_empty/o_count (registered FIFO status);
//        o_tx_start/o_tx_data (to uart_tx i_start/i_data); i_tx_busy/i_tx_done (from uart_tx);
//        o_busy (sequencer active or bytes pending).
// Option: define UART_TX_FIFO_OVERFLOW_FLAG_EN to add i_ovf_clr/o_overflow (sticky dropped-write flag).
`timescale 1ns/1ps
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int ADDR_W = UART_ADDR_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_wr_en,
   input  logic [UART_DATA_W-1:0] i_wr_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [ADDR_W:0]        o_count,
   output logic                   o_tx_start,
   output logic [UART_DATA_W-1:0] o_tx_data,
   input  logic                   i_tx_busy,
   input  logic                   i_tx_done,
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
   input  logic                   i_ovf_clr,
   output logic                   o_overflow,
`endif
   output logic                   o_busy
);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   tx_state_t              state, state_nxt;
   logic [ADDR_W-1:0]      wr_ptr, rd_ptr;
   logic [ADDR_W:0]        count, count_nxt;
   logic                   done_prev;
   logic                   wr_ok, pop;
   logic [UART_DATA_W-1:0] rd_data;

   // Full check uses the pre-edge count, so a same-cycle pop never makes room.
   assign wr_ok     = i_wr_en && (count != DEPTH);
   assign count_nxt = count + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, pop};

   uart_fifo_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk     (i_clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr),
      .wr_data (i_wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if ((count != '0) && i_enable && !i_tx_busy) begin
               pop       = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH:    state_nxt = WAIT_DONE;
         // Edge-detect done so a level held high finishes only one frame.
         WAIT_DONE: if (i_tx_done && !done_prev) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_full     <= 1'b0;
         o_empty    <= 1'b1;
         done_prev  <= 1'b0;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
      end else begin
         state      <= state_nxt;
         done_prev  <= i_tx_done;
         o_tx_start <= pop;
         count      <= count_nxt;
         o_full     <= (count_nxt == DEPTH);
         o_empty    <= (count_nxt == '0);
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            o_tx_data <= rd_data;
            rd_ptr    <= rd_ptr + 1'b1;
         end
      end
   end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
   // Set has priority over clear so a drop in the clearing cycle is not lost.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow <= 1'b0;
      end else if (i_wr_en && (count == DEPTH)) begin
         o_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
         o_overflow <= 1'b0;
      end
   end
`endif

   assign o_count = count;
   assign o_busy  = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a behavioural uart_tx stand-in
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   localparam int ADDR_W        = 4;
   localparam int DEPTH         = 16;
   localparam int TICKS_PER_BIT = 4;
   localparam int FRAME_CYC     = 10 * TICKS_PER_BIT;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic              wr_en = 1'b0;
   logic [7:0]        wr_data = 8'h00;
   logic              full, empty, tx_start, busy;
   logic [ADDR_W:0]   count;
   logic [7:0]        tx_data;
   logic              tx_busy = 1'b0;
   logic              tx_done = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
   logic              ovf_clr = 1'b0;
   logic              overflow;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_enable   (enable),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .o_full     (full),
      .o_empty    (empty),
      .o_count    (count),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .i_tx_busy  (tx_busy),
      .i_tx_done  (tx_done),
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
      .i_ovf_clr  (ovf_clr),
      .o_overflow (overflow),
`endif
      .o_busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus an "in flight" flag for the byte handed to uart_tx.
   logic [7:0] m_q[$];
   logic       m_inflight = 1'b0;
   logic [7:0] m_last     = 8'h00;
   logic       m_ovf      = 1'b0;
   logic       done_hist  = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         tx_cnt = 0;

   initial begin
      logic p_rst, p_en, p_wr, p_busy, p_done, p_clr, exp_start, full_pre;
      logic [7:0] p_d;
      forever begin
         @(posedge clk);
         p_rst = rst; p_en = enable; p_wr = wr_en; p_d = wr_data;
         p_busy = tx_busy; p_done = tx_done; p_clr = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
         p_clr = ovf_clr;
`endif
         #1;
         if (p_rst || rst) begin
            m_q.delete(); m_inflight = 1'b0; m_last = 8'h00; m_ovf = 1'b0; done_hist = 1'b0;
         end else begin
            full_pre  = (m_q.size() == DEPTH);
            exp_start = !m_inflight && (m_q.size() > 0) && p_en && !p_busy;
            if (m_inflight && p_done && !done_hist) m_inflight = 1'b0;
            if (exp_start) begin
               m_last     = m_q.pop_front();
               m_inflight = 1'b1;
            end
            if (p_wr && !full_pre) m_q.push_back(p_d);
            if (p_wr && full_pre) m_ovf = 1'b1;
            else if (p_clr) m_ovf = 1'b0;
            done_hist = p_done;
            check("mon_tx_start", tx_start, exp_start);
            check("mon_tx_data", tx_data, m_last);
            check("mon_count", count, m_q.size());
            check("mon_empty", empty, m_q.size() == 0);
            check("mon_full", full, m_q.size() == DEPTH);
            check("mon_busy", busy, m_inflight || (m_q.size() > 0));
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
            check("mon_overflow", overflow, m_ovf);
`endif
         end
         // uart_tx stand-in: frame lasts FRAME_CYC cycles, then one-cycle done pulse.
         tx_done = 1'b0;
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
               tx_busy = 1'b0;
               tx_done = 1'b1;
            end
         end else if (tx_start) begin
            tx_busy = 1'b1;
            tx_cnt  = FRAME_CYC;
            rx_q.push_back(tx_data);
         end
      end
   end

   task automatic drain(input string tag);
      int n = 0;
      while (!(m_q.size() == 0 && !m_inflight && tx_cnt == 0) && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      check({tag, "_drain_in_time"}, n < 3000, 1'b1);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic check_rx(input string tag, input int base);
      check({tag, "_rx_len"}, rx_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < rx_q.size()) check({tag, "_rx_byte"}, rx_q[base + i], exp_q[i]);
   endtask

   task automatic burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int n, output int peak);
      logic [7:0] bytes [4];
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      peak = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); wr_en = 1'b1; wr_data = bytes[i];
         @(posedge clk); #2;
         if (int'(count) > peak) peak = int'(count);
      end
      @(negedge clk); wr_en = 1'b0;
      repeat (3) begin
         @(posedge clk); #2;
         if (int'(count) > peak) peak = int'(count);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, peak;
      repeat (3) @(posedge clk);
      #2;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_count", count, 0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      @(negedge clk); rst = 1'b0; enable = 1'b1;

      // Single byte: start pulse exactly one edge after the write edge.
      base = rx_q.size();
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h0D;
      @(posedge clk); #2; check("single_no_early_start", tx_start, 1'b0); wr_en = 1'b0;
      @(posedge clk); #2; check("single_start", tx_start, 1'b1); check("single_data", tx_data, 8'h0D);
      @(posedge clk); #2; check("single_pulse_width", tx_start, 1'b0);
      drain("single");
      exp_q = {8'h0D}; check_rx("single", base);
      check("single_empty_after", empty, 1'b1);
      check("single_busy_after", busy, 1'b0);

      // Burst of four.
      base = rx_q.size();
      burst(8'hAB, 8'h55, 8'h00, 8'hFF, 4, peak);
      check("burst_peak_count", peak, 3);
      drain("burst");
      exp_q = {8'hAB, 8'h55, 8'h00, 8'hFF}; check_rx("burst", base);

      // Fill with launches disabled, then overflow and write-while-full with a concurrent pop.
      enable = 1'b0; base = rx_q.size();
      for (int v = 1; v <= 17; v++) begin
         @(negedge clk); wr_en = 1'b1; wr_data = 8'(v);
      end
      @(negedge clk); wr_en = 1'b0;
      check("full_flag", full, 1'b1);
      check("full_count", count, 16);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
      check("full_overflow", overflow, 1'b1);
`endif
      enable = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
      @(posedge clk); #2;
      check("full_pop_wr_count", count, 15);
      check("full_pop_start", tx_start, 1'b1);
      wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
      @(negedge clk); ovf_clr = 1'b1;
      @(posedge clk); #2; check("ovf_cleared", overflow, 1'b0); ovf_clr = 1'b0;
`endif
      drain("full");
      exp_q.delete();
      for (int v = 1; v <= 16; v++) exp_q.push_back(8'(v));
      check_rx("full", base);

      // Simultaneous write and pop at count = 1.
      enable = 1'b0; base = rx_q.size();
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
      @(negedge clk); enable = 1'b1; wr_data = 8'hC3;
      @(posedge clk); #2;
      check("simul_count", count, 1);
      check("simul_start", tx_start, 1'b1);
      wr_en = 1'b0;
      drain("simul");
      exp_q = {8'h3C, 8'hC3}; check_rx("simul", base);

      // Enable gating mid-frame with two bytes queued.
      base = rx_q.size();
      burst(8'hA1, 8'hA2, 8'hA3, 8'h00, 3, peak);
      repeat (10) @(posedge clk);
      #2; enable = 1'b0;
      repeat (80) @(posedge clk);
      #2;
      check("gate_launches", rx_q.size() - base, 1);
      check("gate_count", count, 2);
      check("gate_busy", busy, 1'b1);
      enable = 1'b1;
      drain("gate");
      exp_q = {8'hA1, 8'hA2, 8'hA3}; check_rx("gate", base);

      // Reset during the data bits of 8'hAB with three bytes queued.
      base = rx_q.size();
      burst(8'hAB, 8'h01, 8'h02, 8'h03, 4, peak);
      repeat (8) @(posedge clk);
      #3; rst = 1'b1;
      #1;
      check("rstmid_count", count, 0);
      check("rstmid_empty", empty, 1'b1);
      check("rstmid_tx_start", tx_start, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      exp_q = {8'hAB}; check_rx("rstmid", base);
      check("rstmid_count_after", count, 0);
      drain("rstmid");

      // Randomized traffic against the reference model.
      base = rx_q.size();
      exp_q.delete();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_data = 8'($urandom);
         enable  = ($urandom_range(0, 3) != 0);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
         ovf_clr = ($urandom_range(0, 15) == 0);
`endif
         @(posedge clk);
         if (wr_en && (exp_q.size() < DEPTH + rx_q.size() - base)) exp_q.push_back(wr_data);
      end
      @(negedge clk); wr_en = 1'b0; enable = 1'b1;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
      ovf_clr = 1'b0;
`endif
      drain("rand");
      check("rand_empty_end", empty, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer sitting directly upstream of uart_tx.
- Accepts bytes from the host side in bursts and stores them in a circular FIFO.
- Drains one byte at a time into uart_tx via its i_start/i_data/o_busy/o_done handshake.
- Lets the host write whole messages without tracking the serial bit timing.

Parameters:
ADDR_W, 4, FIFO address width; depth DEPTH = 2**ADDR_W (default 16 bytes).

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_enable  in  1  1 = launches permitted; 0 = no new launch, in-flight byte completes.
i_wr_en  in  1  write strobe, one byte per cycle.
i_wr_data  in  8  byte to enqueue.
o_full  out  1  FIFO holds DEPTH bytes.
o_empty  out  1  FIFO holds 0 bytes.
o_count  out  ADDR_W+1  bytes currently stored (excludes the byte in flight).
o_tx_start  out  1  one-cycle start pulse to uart_tx i_start.
o_tx_data  out  8  byte to uart_tx i_data.
i_tx_busy  in  1  from uart_tx o_busy.
i_tx_done  in  1  from uart_tx o_done.
o_busy  out  1  1 whenever FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async, i_rst=1):
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_empty=1, o_full=0, o_count=0.
  - o_tx_start=0, o_tx_data=8'h00, o_busy=0, FSM = IDLE.
  - FIFO RAM contents are not reset.
- Write: accepted at a rising edge when i_wr_en=1 and count<DEPTH.
  - mem[wr_ptr] <= i_wr_data; wr_ptr wraps modulo DEPTH.
  - A write while full is dropped silently; pointers and count are unchanged.
  - A pop in the same cycle does not make room for that write: the full check uses pre-edge count.
- Flags and count: o_full, o_empty and o_count are registered and reflect count after each edge.
  - Simultaneous accepted write and pop leaves count unchanged.
- FSM states:
  - IDLE: if count>0, i_enable=1 and i_tx_busy=0:
    - o_tx_data <= mem[rd_ptr], o_tx_start <= 1, rd_ptr++ (wrap), count--.
    - Go to LAUNCH.
  - LAUNCH (1 cycle): o_tx_start <= 0; go to WAIT_DONE.
  - WAIT_DONE: on detected rising edge of i_tx_done (i_tx_done=1 and previous-cycle i_tx_done=0), go to IDLE.
    - i_tx_done held high is counted once.
- Latency:
  - Write sampled at edge k into an empty FIFO with the FSM idle: o_tx_start is high for exactly the cycle after edge k+1.
  - Back-to-back bytes: next o_tx_start occurs no earlier than 1 cycle after the done edge is seen, and only once i_tx_busy=0.
- o_tx_data is held stable from the start pulse until the next launch.
- i_enable falling mid-frame: the current byte completes; the FSM parks in IDLE with data retained.
- Wrap-around: pointers are ADDR_W bits, count is ADDR_W+1 bits; full/empty are derived from count only.
- Reset mid-frame: FIFO contents are discarded and o_tx_start is forced low immediately. uart_tx finishing its frame afterwards is harmless; the done edge is ignored in IDLE.

Optional Feature:
Macro UART_TX_FIFO_OVERFLOW_FLAG_EN.
- Defined: adds ports i_ovf_clr (in, 1) and o_overflow (out, 1).
  - o_overflow is sticky; it sets on any write attempt while full.
  - It clears on i_ovf_clr=1 and resets to 0.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists; dropped writes are silent.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, LAUNCH, WAIT_DONE).
  - Default ADDR_W constant.
  - Byte width constant UART_DATA_W=8.
- Sub-module uart_fifo_mem: simple dual-port RAM, DEPTH x 8, synchronous write, asynchronous read.
- Pointers, count and FSM stay in uart_tx_fifo.

Test Plan:
- Single byte: write 8'h0D into empty FIFO with uart_tx TICKS_PER_BIT=4. Expect:
  - one o_tx_start pulse 2 edges after the write, o_tx_data=8'h0D;
  - uart_rx loopback yields 8'h0D;
  - o_empty=1 and o_busy=0 after done.
- Burst: write 8'hAB,8'h55,8'h00,8'hFF on consecutive cycles. Expect:
  - o_count peaks at 3 (first byte already launched);
  - four frames in order; four o_tx_start pulses, each after the prior done edge.
- Full/overflow: with i_enable=0, write 17 bytes 8'h01..8'h11. Expect:
  - o_full=1 and o_count=16; 8'h11 dropped;
  - o_overflow=1 when the macro is defined;
  - after i_enable=1, sixteen bytes 8'h01..8'h10 are received.
- Simultaneous write and pop at count=1, plus a write while full with concurrent pop. Expect:
  - first case: count stays 1;
  - second case: full-time write dropped, count becomes 15.
- Reset mid-frame: assert i_rst during the data bits of 8'hAB with 3 bytes queued. Expect:
  - immediately o_count=0, o_empty=1, o_tx_start=0;
  - no further launches after reset deasserts.
- Enable gating: deassert i_enable mid-frame with 2 bytes queued. Expect:
  - the current byte completes, then no o_tx_start;
  - re-enable launches the remaining 2 bytes in order.
